// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: default operand width and FSM encoding.
package serial_adder_pkg;

   localparam int WIDTH_DEFAULT = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell shared across the codebase.
module full_adder (
   output logic sum,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one operand bit per clock,
// LSB first, producing {cout,sum} = a + b + cin after WIDTH shift cycles.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Counter must reach WIDTH without wrapping, including WIDTH=1.
   localparam int CW = $clog2(WIDTH + 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_sum;
   logic             fa_cout;
   logic             last;

   full_adder u_fa (
      .sum  (fa_sum),
      .cout (fa_cout),
      .a    (opa[0]),
      .b    (opb[0]),
      .cin  (carry)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the first (LSB) result.
   if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_sum;
   end else begin : g_res_wn
      assign res_next = {fa_sum, res[WIDTH-1:1]};
   end

   // Final shift cycle: the cell output for the MSB is being computed this cycle.
   assign last = (cnt == CW'(WIDTH - 1));

   // Control: FSM state plus registered busy/done so outputs come straight from flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= ST_SHIFT;
                  busy  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (last) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Datapath: operand/result shifting, carry flop, bit counter and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa   <= '0;
         opb   <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  opa   <= a;
                  opb   <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            ST_SHIFT: begin
               opa   <= opa >> 1;
               opb   <= opb >> 1;
               carry <= fa_cout;
               res   <= res_next;
               cnt   <= cnt + CW'(1);
               // Publish on the same edge that leaves SHIFT, including the last bit.
               if (last) begin
                  sum  <= res_next;
                  cout <= fa_cout;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH 8 (primary), 1 and 16.
module tb_serial_adder;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;

   logic        busy8, done8, cout8;
   logic [7:0]  sum8;
   logic        busy1, done1, cout1;
   logic [0:0]  sum1;
   logic        busy16, done16, cout16;
   logic [15:0] sum16;

   int errs  = 0;
   int total = 0;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .a(a[7:0]), .b(b[7:0]), .cin(cin),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .a(a[0:0]), .b(b[0:0]), .cin(cin),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start), .a(a[15:0]), .b(b[15:0]), .cin(cin),
      .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Results captured by go8
   logic [7:0] dsum;
   logic       dcout;
   int         dlat;
   int         dpulses;
   logic       dboth;
   logic       dbusy1;

   // One 8-bit operation: start for one cycle, optional stray start at cycle
   // pulse_at, optional reset at cycle rst_at; 20 cycles observed.
   task automatic go8(input logic [7:0] aa, input logic [7:0] bb, input logic c,
                      input int pulse_at, input int rst_at);
      dlat = -1; dpulses = 0; dboth = 1'b0; dsum = '0; dcout = 1'b0; dbusy1 = 1'b0;
      @(negedge clk);
      a = {24'd0, aa}; b = {24'd0, bb}; cin = c; start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start = (k == pulse_at);
         if (k == 1) dbusy1 = busy8;
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            check("rstmid_busy", busy8, 1'b0);
            check("rstmid_done", done8, 1'b0);
            check("rstmid_sum", sum8, 8'h00);
            check("rstmid_cout", cout8, 1'b0);
         end else begin
            rst = 1'b0;
         end
         if (busy8 && done8) dboth = 1'b1;
         if (done8) begin
            dpulses++;
            if (dlat < 0) begin
               dlat = k - 1;
               dsum = sum8;
               dcout = cout8;
            end
         end
      end
      rst = 1'b0;
   endtask

   // Same operands into all three widths; checks sum, carry, latency, pulse count.
   task automatic run_all(input logic [31:0] aa, input logic [31:0] bb, input logic c);
      int l1, l8, l16, n1, n8, n16;
      logic [15:0] s16; logic [7:0] s8; logic s1;
      logic o1, o8, o16;
      logic [32:0] e1, e8, e16;
      l1 = -1; l8 = -1; l16 = -1; n1 = 0; n8 = 0; n16 = 0;
      s1 = 1'b0; s8 = '0; s16 = '0; o1 = 1'b0; o8 = 1'b0; o16 = 1'b0;
      e1  = 33'(aa[0])     + 33'(bb[0])     + 33'(c);
      e8  = 33'(aa[7:0])   + 33'(bb[7:0])   + 33'(c);
      e16 = 33'(aa[15:0])  + 33'(bb[15:0])  + 33'(c);
      @(negedge clk);
      a = aa; b = bb; cin = c; start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done1)  begin n1++;  if (l1 < 0)  begin l1 = k - 1;  s1 = sum1[0]; o1 = cout1;  end end
         if (done8)  begin n8++;  if (l8 < 0)  begin l8 = k - 1;  s8 = sum8;  o8 = cout8;  end end
         if (done16) begin n16++; if (l16 < 0) begin l16 = k - 1; s16 = sum16; o16 = cout16; end end
      end
      check($sformatf("w1_sum a=%0h b=%0h c=%0d", aa, bb, c), s1, e1[0]);
      check($sformatf("w1_cout a=%0h b=%0h c=%0d", aa, bb, c), o1, e1[1]);
      check("w1_lat", l1, 1);
      check("w1_pulses", n1, 1);
      check($sformatf("w8_sum a=%0h b=%0h c=%0d", aa, bb, c), s8, e8[7:0]);
      check($sformatf("w8_cout a=%0h b=%0h c=%0d", aa, bb, c), o8, e8[8]);
      check("w8_lat", l8, 8);
      check("w8_pulses", n8, 1);
      check($sformatf("w16_sum a=%0h b=%0h c=%0d", aa, bb, c), s16, e16[15:0]);
      check($sformatf("w16_cout a=%0h b=%0h c=%0d", aa, bb, c), o16, e16[16]);
      check("w16_lat", l16, 16);
      check("w16_pulses", n16, 1);
   endtask

   initial begin
      int rises[$];
      int ndone;
      logic pbusy, pdone, wide, unstable;
      logic [7:0] psum;
      logic [7:0] hold_exp [3];

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_busy", busy8, 1'b0);
      check("reset_done", done8, 1'b0);
      check("reset_sum", sum8, 8'h00);
      check("reset_cout", cout8, 1'b0);
      check("reset_sum16", sum16, 16'h0000);
      check("reset_busy1", busy1, 1'b0);
      rst = 1'b0;

      // First edge after reset release with start high is accepted
      go8(8'h5A, 8'h3C, 1'b0, 0, 0);
      check("5a3c_busy_first", dbusy1, 1'b1);
      check("5a3c_lat", dlat, 8);
      check("5a3c_pulses", dpulses, 1);
      check("5a3c_sum", dsum, 8'h96);
      check("5a3c_cout", dcout, 1'b0);
      check("5a3c_excl", dboth, 1'b0);
      check("5a3c_hold_sum", sum8, 8'h96);

      go8(8'hFF, 8'h01, 1'b0, 0, 0);
      check("ff01_sum", dsum, 8'h00);
      check("ff01_cout", dcout, 1'b1);
      check("ff01_lat", dlat, 8);

      go8(8'hFF, 8'hFF, 1'b1, 0, 0);
      check("ffff1_sum", dsum, 8'hFF);
      check("ffff1_cout", dcout, 1'b1);

      // Stray start while shifting must be ignored
      go8(8'h10, 8'h20, 1'b0, 3, 0);
      check("ign_sum", dsum, 8'h30);
      check("ign_cout", dcout, 1'b0);
      check("ign_lat", dlat, 8);
      check("ign_pulses", dpulses, 1);

      // Reset during SHIFT cycle 4 abandons the operation
      go8(8'hAA, 8'h55, 1'b0, 0, 5);
      check("abort_pulses", dpulses, 0);
      check("abort_sum_after", sum8, 8'h00);
      check("abort_busy_after", busy8, 1'b0);

      go8(8'h01, 8'h02, 1'b0, 0, 0);
      check("after_abort_sum", dsum, 8'h03);
      check("after_abort_cout", dcout, 1'b0);

      // Start held high: three back-to-back operations, operand A changed after each done
      hold_exp[0] = 8'h33; hold_exp[1] = 8'h62; hold_exp[2] = 8'hA2;
      ndone = 0; wide = 1'b0; unstable = 1'b0;
      @(negedge clk);
      a = 32'h11; b = 32'h22; cin = 1'b0; start = 1'b1;
      pbusy = busy8; pdone = done8; psum = sum8;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (busy8 && !pbusy) rises.push_back(k);
         if (done8 && pdone) wide = 1'b1;
         if (!done8 && sum8 !== psum) unstable = 1'b1;
         if (done8) begin
            if (ndone < 3) check($sformatf("hold_sum%0d", ndone), sum8, hold_exp[ndone]);
            ndone++;
            if (ndone == 1) a = 32'h40;
            if (ndone == 2) a = 32'h80;
            if (ndone == 3) start = 1'b0;
         end
         pbusy = busy8; pdone = done8; psum = sum8;
      end
      start = 1'b0;
      check("hold_ndone", ndone, 3);
      check("hold_nstarts", rises.size(), 3);
      check("hold_gap1", (rises.size() >= 2) ? rises[1] - rises[0] : 0, 10);
      check("hold_gap2", (rises.size() >= 3) ? rises[2] - rises[1] : 0, 10);
      check("hold_width", wide, 1'b0);
      check("hold_stable", unstable, 1'b0);

      // Let the 1- and 16-bit instances drain before the multi-width runs
      repeat (20) @(negedge clk);

      run_all(32'h0000, 32'h0000, 1'b0);
      run_all(32'h0001, 32'h0001, 1'b1);
      run_all(32'hFFFF, 32'h0001, 1'b0);
      run_all(32'hFFFF, 32'hFFFF, 1'b1);
      run_all(32'h1234, 32'h4321, 1'b0);
      run_all(32'h8000, 32'h8080, 1'b0);
      for (int i = 0; i < 1000; i++) begin
         run_all($urandom, $urandom, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errs, total);
      $finish;
   end

endmodule
